// File: rtl/rs232_rx_parity_checker.sv
// rs232_rx_parity_checker
// Receives one asynchronous RS232 frame (start, DATA_BITS data LSB first,
// parity, stop) from the RX pin, checks the parity bit using the same rule as
// the transmit-side generator and presents the word with parity/framing
// status. A one-cycle data_valid pulse marks every completed frame, errored
// or not; the status outputs qualify that pulse and hold until the next one.
module rs232_rx_parity_checker #(
   parameter int CLKS_PER_BIT = 16,   // clk cycles per bit period, >= 4
   parameter int DATA_BITS    = 7,    // data bits per frame
   parameter bit PARITY_ODD   = 1'b0  // 0: parity = ^data, 1: parity = ~^data
) (
   input  logic                 clk,
   input  logic                 rst,          // asynchronous, active low
   input  logic                 rxd,          // serial line, idle high, async to clk
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Counter values at which the line is sampled: the start bit is checked
   // half a period in, every later bit one full period after the previous
   // sample, so all samples land near the middle of their bit.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Registers and their next values
   // ------------------------------------------------------------------
   logic                 sync1_q;        // first synchroniser stage
   logic                 rxs_q;          // synchronised rxd
   logic                 rxs_prev_q;     // rxs delayed one clk for edge detect

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bitidx_q, bitidx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 pbit_q, pbit_d;

   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 framing_err_q, framing_err_d;

   // ------------------------------------------------------------------
   // Decodes shared by the next-state and output processes
   // ------------------------------------------------------------------
   logic start_edge;    // falling edge on the synchronised line
   logic half_tick;     // centre of the start bit reached
   logic bit_tick;      // one full bit period elapsed
   logic capture;       // sample the current data bit into shreg
   logic frame_done;    // stop bit sampled this cycle
   logic exp_parity;    // parity bit the transmitter should have sent

   assign start_edge = rxs_prev_q & ~rxs_q;
   assign half_tick  = (cnt_q == HALF_LAST);
   assign bit_tick   = (cnt_q == FULL_LAST);
   assign capture    = (state_q == S_DATA) && bit_tick;
   assign frame_done = (state_q == S_STOP) && bit_tick;
   assign exp_parity = (^shreg_q) ^ PARITY_ODD;

   // State register plus all datapath flops; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q       <= 1'b1;
         rxs_q         <= 1'b1;
         rxs_prev_q    <= 1'b1;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bitidx_q      <= '0;
         shreg_q       <= '0;
         pbit_q        <= 1'b0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
      end else begin
         sync1_q       <= rxd;
         rxs_q         <= sync1_q;
         rxs_prev_q    <= rxs_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bitidx_q      <= bitidx_d;
         shreg_q       <= shreg_d;
         pbit_q        <= pbit_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         parity_err_q  <= parity_err_d;
         framing_err_q <= framing_err_d;
      end
   end

   // Next-state logic: walks start -> data -> parity -> stop, dropping a
   // start bit that is no longer low at its centre as a line glitch
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            // only an edge starts a frame, so a line stuck low (break)
            // must return high before the next frame is accepted
            if (start_edge) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (half_tick) begin
               state_d = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_tick && (bitidx_q == LAST_BIT)) begin
               state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output/datapath logic: bit timing, data capture and end-of-frame report
   always_comb begin
      cnt_d         = cnt_q;
      bitidx_d      = bitidx_q;
      pbit_d        = pbit_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      parity_err_d  = parity_err_q;
      framing_err_d = framing_err_q;

      // the bit timer restarts on every state change and after each
      // full period inside the data phase
      if ((state_d != state_q) || (state_q == S_IDLE) || bit_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // data bit index: cleared while waiting for the start bit,
      // advanced after each captured data bit
      if (state_q == S_IDLE || state_q == S_START) begin
         bitidx_d = '0;
      end else if (capture) begin
         bitidx_d = bitidx_q + BW'(1);
      end

      if ((state_q == S_PARITY) && bit_tick) begin
         pbit_d = rxs_q;
      end

      // the stop bit sample publishes the frame; the flops make the
      // results and the pulse visible the cycle after, with state IDLE
      if (frame_done) begin
         data_out_d    = shreg_q;
         data_valid_d  = 1'b1;
         parity_err_d  = (pbit_q != exp_parity);
         framing_err_d = ~rxs_q;
      end
   end

   // Per-bit capture into the shift register: bit gi loads the line only
   // when the bit index points at it, all other bits hold
   generate
      for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shreg
         assign shreg_d[gi] = (capture && (bitidx_q == BW'(gi))) ? rxs_q
                                                                  : shreg_q[gi];
      end
   endgenerate

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign parity_err  = parity_err_q;
   assign framing_err = framing_err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_rx_parity_checker.sv
// tb_rs232_rx_parity_checker
// Drives RS232 frames into an even-parity and an odd-parity receiver sharing
// one line. Expected words and status flags come from a frame-level model
// (ones count of the data, stop bit level); pulses are collected into queues
// by a monitor and matched against the expectations after each frame.
module tb_rs232_rx_parity_checker;

   localparam int CPB = 16;
   localparam int DW  = 7;
   localparam int LATENCY = 2 + CPB / 2 + (DW + 2) * CPB + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rxd = 1'b1;

   logic [DW-1:0] dout_e, dout_o;
   logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

   always #5 clk = ~clk;

   rs232_rx_parity_checker #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY_ODD(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd),
      .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
      .framing_err(fe_e), .busy(busy_e)
   );

   rs232_rx_parity_checker #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY_ODD(1'b1)
   ) dut_odd (
      .clk(clk), .rst(rst), .rxd(rxd),
      .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
      .framing_err(fe_o), .busy(busy_o)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          pe;
      logic          fe;
   } res_t;

   typedef struct {
      logic [DW-1:0] d;      // data sent
      logic          p;      // parity bit sent
      logic          s;      // stop bit sent
      int            gap;    // idle bits after the frame
      logic [DW-1:0] exp_d;  // expected results, even-parity receiver
      logic          exp_pe;
      logic          exp_fe;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   pulse_cyc = 0;
   res_t got_e[$], got_o[$], exp_e[$], exp_o[$];
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: what a receiver with the given parity sense reports for a frame
   function automatic res_t model(input logic [DW-1:0] d, input logic p,
                                  input logic s, input bit odd);
      res_t r;
      logic ones_odd;
      ones_odd = (($countones(d) % 2) == 1);
      r.d  = d;
      r.pe = (p != (ones_odd ^ odd));
      r.fe = !s;
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every data_valid pulse; busy must already be low in that cycle
   always @(negedge clk) begin
      if (dv_e) begin
         got_e.push_back({dout_e, pe_e, fe_e});
         pulse_cyc <= cyc;
         chk("busy_in_valid_even", {31'd0, busy_e}, 32'd0);
      end
      if (dv_o) begin
         got_o.push_back({dout_o, pe_o, fe_o});
         chk("busy_in_valid_odd", {31'd0, busy_o}, 32'd0);
      end
   end

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < DW; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
   endtask

   task automatic expect_frame(input logic [DW-1:0] d, input logic p, input logic s);
      exp_e.push_back(model(d, p, s, 1'b0));
      exp_o.push_back(model(d, p, s, 1'b1));
   endtask

   // Match collected pulses against expectations, bounded wait for stragglers
   task automatic drain(input string tag);
      int   t;
      res_t e, g;
      t = 0;
      while ((got_e.size() < exp_e.size() || got_o.size() < exp_o.size()) && t < 4 * CPB) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("%s pulses_even", tag), got_e.size(), exp_e.size());
      chk($sformatf("%s pulses_odd", tag), got_o.size(), exp_o.size());
      while (exp_e.size() > 0) begin
         e = exp_e.pop_front();
         g = (got_e.size() > 0) ? got_e.pop_front() : 'x;
         chk($sformatf("%s data_even", tag), {25'd0, g.d}, {25'd0, e.d});
         chk($sformatf("%s perr_even", tag), {31'd0, g.pe}, {31'd0, e.pe});
         chk($sformatf("%s ferr_even", tag), {31'd0, g.fe}, {31'd0, e.fe});
      end
      while (exp_o.size() > 0) begin
         e = exp_o.pop_front();
         g = (got_o.size() > 0) ? got_o.pop_front() : 'x;
         chk($sformatf("%s data_odd", tag), {25'd0, g.d}, {25'd0, e.d});
         chk($sformatf("%s perr_odd", tag), {31'd0, g.pe}, {31'd0, e.pe});
         chk($sformatf("%s ferr_odd", tag), {31'd0, g.fe}, {31'd0, e.fe});
      end
      got_e.delete();
      got_o.delete();
   endtask

   task automatic chk_cleared(input string tag);
      chk($sformatf("%s data_out", tag), {25'd0, dout_e}, 32'd0);
      chk($sformatf("%s data_valid", tag), {31'd0, dv_e}, 32'd0);
      chk($sformatf("%s parity_err", tag), {31'd0, pe_e}, 32'd0);
      chk($sformatf("%s framing_err", tag), {31'd0, fe_e}, 32'd0);
      chk($sformatf("%s busy", tag), {31'd0, busy_e}, 32'd0);
      chk($sformatf("%s busy_odd", tag), {31'd0, busy_o}, 32'd0);
      chk($sformatf("%s data_out_odd", tag), {25'd0, dout_o}, 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      logic          rp, rs;
      int            gap, seen_busy;

      tbl[0] = '{7'h55, 1'b0, 1'b1, 1, 7'h55, 1'b0, 1'b0};
      tbl[1] = '{7'h01, 1'b0, 1'b1, 1, 7'h01, 1'b1, 1'b0};
      tbl[2] = '{7'h2A, 1'b1, 1'b1, 0, 7'h2A, 1'b0, 1'b0};
      tbl[3] = '{7'h3C, 1'b0, 1'b1, 1, 7'h3C, 1'b0, 1'b0};
      tbl[4] = '{7'h00, 1'b1, 1'b1, 1, 7'h00, 1'b1, 1'b0};
      tbl[5] = '{7'h7F, 1'b1, 1'b0, 2, 7'h7F, 1'b0, 1'b1};
      tbl[6] = '{7'h12, 1'b0, 1'b1, 1, 7'h12, 1'b0, 1'b0};
      tbl[7] = '{7'h0F, 1'b1, 1'b0, 2, 7'h0F, 1'b1, 1'b1};
      tbl[8] = '{7'h40, 1'b1, 1'b1, 1, 7'h40, 1'b0, 1'b0};

      // reset state
      repeat (4) @(negedge clk);
      #1;
      chk_cleared("reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // clean frame and its latency from the falling edge
      expect_frame(7'h55, 1'b0, 1'b1);
      send_frame(7'h55, 1'b0, 1'b1);
      drain("t1");
      chk("t1 latency", pulse_cyc - start_cyc, LATENCY);
      idle_bits(1);

      // table of frames; even-receiver results are fixed constants
      for (int i = 0; i < 9; i++) begin
         exp_e.push_back({tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe});
         exp_o.push_back(model(tbl[i].d, tbl[i].p, tbl[i].s, 1'b1));
         send_frame(tbl[i].d, tbl[i].p, tbl[i].s);
         idle_bits(tbl[i].gap);
         drain($sformatf("tbl%0d", i));
      end

      // break: stop low and line held low, then a clean frame
      expect_frame(7'h7F, 1'b1, 1'b0);
      send_frame(7'h7F, 1'b1, 1'b0);
      repeat (40) send_bit(1'b0);
      drain("t3 break");
      idle_bits(2);
      expect_frame(7'h0F, 1'b0, 1'b1);
      send_frame(7'h0F, 1'b0, 1'b1);
      idle_bits(1);
      drain("t3 after");

      // short glitch is dropped at the start-bit centre
      seen_busy = 0;
      rxd = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy_e) seen_busy = 1;
      end
      rxd = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (busy_e) seen_busy = 1;
      end
      chk("t4 busy_seen", seen_busy, 1);
      chk("t4 busy_idle", {31'd0, busy_e}, 32'd0);
      idle_bits(2);
      drain("t4 glitch");

      // reset in the middle of data bit 3 aborts the frame
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rxd = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      chk("t5 busy_before_reset", {31'd0, busy_e}, 32'd1);
      rst = 1'b0;
      #1;
      chk_cleared("t5 in_reset");
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle_bits(2);
      drain("t5 aborted");
      expect_frame(7'h2A, 1'b1, 1'b1);
      send_frame(7'h2A, 1'b1, 1'b1);
      idle_bits(1);
      drain("t5 after");

      // back-to-back frames, even-correct then odd-correct parity
      expect_frame(7'h00, 1'b0, 1'b1);
      expect_frame(7'h7F, 1'b1, 1'b1);
      send_frame(7'h00, 1'b0, 1'b1);
      send_frame(7'h7F, 1'b1, 1'b1);
      idle_bits(1);
      drain("t6 even");
      expect_frame(7'h00, 1'b1, 1'b1);
      expect_frame(7'h7F, 1'b0, 1'b1);
      send_frame(7'h00, 1'b1, 1'b1);
      send_frame(7'h7F, 1'b0, 1'b1);
      idle_bits(1);
      drain("t6 odd");

      // random frames, random parity/stop errors and gaps
      for (int n = 0; n < 40; n++) begin
         rd  = DW'($urandom);
         rp  = 1'($urandom_range(0, 1));
         rs  = ($urandom_range(0, 5) != 0);
         gap = $urandom_range(0, 2);
         if (!rs && gap == 0) gap = 1;
         expect_frame(rd, rp, rs);
         send_frame(rd, rp, rs);
         idle_bits(gap);
         drain($sformatf("rnd%0d", n));
      end

      idle_bits(2);
      drain("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
